// File: rtl/data_cache_if.sv
// CPU-side and memory-side signal bundle for the direct-mapped data cache.
// The slave modport is the cache; the master modport is the surrounding CPU/memory.
interface data_cache_if;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned MADDR_W = 6;
  localparam int unsigned BLK_W   = 32;

  logic               READ;
  logic               WRITE;
  logic [ADDR_W-1:0]  ADDRESS;
  logic [BYTE_W-1:0]  WRITEDATA;
  logic [BYTE_W-1:0]  READDATA;
  logic               BUSYWAIT;
  logic               MEM_READ;
  logic               MEM_WRITE;
  logic [MADDR_W-1:0] MEM_ADDRESS;
  logic [BLK_W-1:0]   MEM_WRITEDATA;
  logic [BLK_W-1:0]   MEM_READDATA;
  logic               MEM_BUSYWAIT;

  modport master (
    output READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
    input  READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );

  modport slave (
    input  READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
    output READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped write-back data cache, 8 blocks x 4 bytes, zero-stall hits and a
// write-back/fetch state machine on misses.
module data_cache (
  input logic        CLK,
  input logic        RESET,
  data_cache_if.slave bus
);
  localparam int unsigned N_BLOCKS = 8;
  localparam int unsigned TAG_W    = 3;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned BLK_W    = 32;

  typedef enum logic [1:0] {S_IDLE, S_MEM_WRITE, S_MEM_READ} state_e;

  state_e              state_q, state_d;
  logic [N_BLOCKS-1:0] valid_q, valid_d;
  logic [N_BLOCKS-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0]    tag_q  [N_BLOCKS];
  logic [TAG_W-1:0]    tag_d  [N_BLOCKS];
  logic [BLK_W-1:0]    data_q [N_BLOCKS];
  logic [BLK_W-1:0]    data_d [N_BLOCKS];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] addr_tag;
  logic [4:0]       bit_lo;
  logic             req;
  logic             hit;

  assign idx      = bus.ADDRESS[4:2];
  assign addr_tag = bus.ADDRESS[7:5];
  assign bit_lo   = {bus.ADDRESS[1:0], 3'b000};
  assign req      = bus.READ || bus.WRITE;
  assign hit      = valid_q[idx] && (tag_q[idx] == addr_tag);

  // Next state, array updates and bus outputs; everything is forced quiet while RESET is high.
  always_comb begin
    state_d           = state_q;
    valid_d           = valid_q;
    dirty_d           = dirty_q;
    tag_d             = tag_q;
    data_d            = data_q;
    bus.READDATA      = 8'h00;
    bus.BUSYWAIT      = 1'b0;
    bus.MEM_READ      = 1'b0;
    bus.MEM_WRITE     = 1'b0;
    bus.MEM_ADDRESS   = 6'h00;
    bus.MEM_WRITEDATA = 32'h0;

    if (!RESET) begin
      unique case (state_q)
        S_IDLE: begin
          if (req) begin
            if (hit) begin
              if (bus.WRITE) begin
                data_d[idx][bit_lo +: 8] = bus.WRITEDATA;
                dirty_d[idx]             = 1'b1;
              end else begin
                bus.READDATA = data_q[idx][bit_lo +: 8];
              end
            end else begin
              bus.BUSYWAIT = 1'b1;
              state_d      = (valid_q[idx] && dirty_q[idx]) ? S_MEM_WRITE : S_MEM_READ;
            end
          end
        end
        S_MEM_WRITE: begin
          bus.MEM_WRITE     = 1'b1;
          bus.MEM_ADDRESS   = {tag_q[idx], idx};
          bus.MEM_WRITEDATA = data_q[idx];
          bus.BUSYWAIT      = 1'b1;
          if (!bus.MEM_BUSYWAIT) state_d = S_MEM_READ;
        end
        S_MEM_READ: begin
          bus.MEM_READ    = 1'b1;
          bus.MEM_ADDRESS = {addr_tag, idx};
          bus.BUSYWAIT    = 1'b1;
          if (!bus.MEM_BUSYWAIT) begin
            data_d[idx]  = bus.MEM_READDATA;
            tag_d[idx]   = addr_tag;
            valid_d[idx] = 1'b1;
            dirty_d[idx] = 1'b0;
            state_d      = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data arrays carry no reset; validity alone decides whether they are used.
  always_ff @(posedge CLK) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end
endmodule
